requant_sched: RTL and testbench

- Sequencer and configurator for the 16b->8b requantization (shift/round/saturate) lanes at the NPU core output.
- Holds a per-channel table of shift enable, round mode and shift amount.
- Streams accumulator beats into the rounding lanes and applies the correct channel config to each beat.
- Absorbs the lanes' 1-cycle registered latency and downstream backpressure with a 2-entry credit-controlled output buffer.

---
 rtl/requant_sched_if.sv | 34 +++
 rtl/requant_sched.sv | 166 ++++++++++++++++
 tb/tb_requant_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/requant_sched_if.sv
// Stream bundle between the requant scheduler, its upstream accumulator
// source, the external rounding lanes and the downstream consumer.
// The scheduler connects through the master modport and its environment
// connects through the slave modport.
interface requant_sched_if #(
  parameter int LANES = 4
);
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic [LANES*16-1:0]   i_in_dat;

  logic                  o_rnd_shift_en;
  logic [1:0]            o_rnd_round_mode;
  logic [4:0]            o_rnd_shift_num;
  logic [LANES*16-1:0]   o_rnd_dat;
  logic [LANES*8-1:0]    i_rnd_dat;

  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [LANES*8-1:0]    o_out_dat;
  logic [3:0]            o_out_ch;

  modport master (
    input  i_in_valid, i_in_dat, i_rnd_dat, i_out_ready,
    output o_in_ready, o_rnd_shift_en, o_rnd_round_mode, o_rnd_shift_num,
           o_rnd_dat, o_out_valid, o_out_dat, o_out_ch
  );

  modport slave (
    output i_in_valid, i_in_dat, i_rnd_dat, i_out_ready,
    input  o_in_ready, o_rnd_shift_en, o_rnd_round_mode, o_rnd_shift_num,
           o_rnd_dat, o_out_valid, o_out_dat, o_out_ch
  );
endinterface

// File: rtl/requant_sched.sv
// Requantization sequencer: holds the per-channel shift/round table, feeds
// accumulator beats into the external rounding lanes with the right channel
// config, and catches the lanes' registered results in a 2-entry buffer.
// Beats are only issued when a buffer slot is guaranteed, counting the beat
// still inside the lanes, so the buffer can never overflow.
module requant_sched #(
  parameter int LANES  = 4,
  parameter int CH_MAX = 16,
  parameter int LEN_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [3:0]         i_cfg_addr,
  input  logic [7:0]         i_cfg_data,
  input  logic               i_start,
  input  logic [4:0]         i_num_ch,
  input  logic [LEN_W-1:0]   i_total_len,
  output logic               o_busy,
  output logic               o_done,
  requant_sched_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [7:0]          cfg_tbl [CH_MAX];
  logic [7:0]          cur_cfg;

  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_cnt;
  logic [4:0]          num_ch_q;
  logic [4:0]          num_ch_eff;
  logic [3:0]          ch_idx;
  logic [3:0]          ch_tag_d;
  logic                inflight;

  logic [LANES*8-1:0]  fifo_dat [2];
  logic [3:0]          fifo_ch  [2];
  logic [1:0]          fifo_cnt;
  logic                rd_ptr;
  logic                wr_ptr;

  logic                push;
  logic                pop;
  logic [2:0]          used;
  logic                has_space;
  logic                in_ready;
  logic                issue;
  logic                last_issue;
  logic                start_ok;

  assign cur_cfg    = cfg_tbl[ch_idx];
  assign push       = inflight;
  assign pop        = (fifo_cnt != 2'd0) & bus.i_out_ready;
  // A slot freed by this cycle's pop can be handed straight to a new beat.
  assign used       = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign has_space  = used < 3'd2;
  assign in_ready   = (state == RUN) & has_space;
  assign issue      = bus.i_in_valid & in_ready;
  assign last_issue = issue & (beat_cnt == len_q - LEN_W'(1));
  assign start_ok   = (state == IDLE) & i_start;
  assign num_ch_eff = (i_num_ch == 5'd0)         ? 5'd1 :
                      (i_num_ch > 5'(CH_MAX))    ? 5'(CH_MAX) : i_num_ch;

  assign bus.o_in_ready       = in_ready;
  assign bus.o_rnd_dat        = issue ? bus.i_in_dat : '0;
  assign bus.o_rnd_shift_en   = issue & cur_cfg[7];
  assign bus.o_rnd_round_mode = issue ? cur_cfg[6:5] : 2'd0;
  assign bus.o_rnd_shift_num  = issue ? cur_cfg[4:0] : 5'd0;
  assign bus.o_out_valid      = fifo_cnt != 2'd0;
  assign bus.o_out_dat        = fifo_dat[rd_ptr];
  assign bus.o_out_ch         = fifo_ch[rd_ptr];
  assign o_busy               = state != IDLE;
  assign o_done               = state == DONE;

  // State register for the job sequencer.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: run until the last beat issues, then drain the lanes and buffer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = (i_total_len == '0) ? DONE : RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if ((fifo_cnt == 2'd0) && !inflight) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Channel config table, writable only while no job is running.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < CH_MAX; i++) cfg_tbl[i] <= 8'd0;
    end else if ((state == IDLE) && i_cfg_we) begin
      cfg_tbl[i_cfg_addr] <= i_cfg_data;
    end
  end

  // Job parameters are latched at start; beat and channel counters advance per issued beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_q    <= '0;
      num_ch_q <= 5'd0;
      ch_idx   <= 4'd0;
      beat_cnt <= '0;
    end else if (start_ok) begin
      len_q    <= i_total_len;
      num_ch_q <= num_ch_eff;
      ch_idx   <= 4'd0;
      beat_cnt <= '0;
    end else if (issue) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
      if ({1'b0, ch_idx} == num_ch_q - 5'd1) ch_idx <= 4'd0;
      else                                    ch_idx <= ch_idx + 4'd1;
    end
  end

  // Track the beat sitting in the rounding lanes and the channel it belongs to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= 1'b0;
      ch_tag_d <= 4'd0;
    end else begin
      inflight <= issue;
      ch_tag_d <= ch_idx;
    end
  end

  // Two-entry result buffer; push and pop may happen in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo_cnt    <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_dat[0] <= '0;
      fifo_dat[1] <= '0;
      fifo_ch[0]  <= 4'd0;
      fifo_ch[1]  <= 4'd0;
    end else begin
      if (push) begin
        fifo_dat[wr_ptr] <= bus.i_rnd_dat;
        fifo_ch[wr_ptr]  <= ch_tag_d;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_requant_sched.sv
// Directed testbench for requant_sched. A small behavioural model stands in
// for the registered rounding lanes; expected results are hand-computed.
module tb_requant_sched;
  localparam int LANES = 4;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_cfg_we;
  logic [3:0]           i_cfg_addr;
  logic [7:0]           i_cfg_data;
  logic                 i_start;
  logic [4:0]           i_num_ch;
  logic [15:0]          i_total_len;
  logic                 o_busy;
  logic                 o_done;
  logic [LANES*8-1:0]   rnd_q = '0;

  requant_sched_if #(.LANES(LANES)) bus ();

  requant_sched #(.LANES(LANES), .CH_MAX(16), .LEN_W(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_data  (i_cfg_data),
    .i_start     (i_start),
    .i_num_ch    (i_num_ch),
    .i_total_len (i_total_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .bus         (bus)
  );

  assign bus.i_rnd_dat = rnd_q;

  always #5 i_clk = ~i_clk;

  // Rounding lane stand-in: optional rounding shift, then saturate to signed 8 bits.
  function automatic logic [7:0] lane_fn(input logic [15:0] x, input logic en,
                                         input logic [1:0] mode, input logic [4:0] n);
    int v;
    int sh;
    v  = int'($signed(x));
    sh = int'(n);
    if (en) begin
      if ((mode != 2'd0) && (sh != 0)) v = v + (1 << (sh - 1));
      v = v >>> sh;
    end
    if (v > 127)       v = 127;
    else if (v < -128) v = -128;
    return 8'(v);
  endfunction

  // Registered lane results, one cycle after issue.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < LANES; l++)
      rnd_q[l*8 +: 8] <= lane_fn(bus.o_rnd_dat[l*16 +: 16], bus.o_rnd_shift_en,
                                 bus.o_rnd_round_mode, bus.o_rnd_shift_num);
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0]          stim [32];
  logic [LANES*8-1:0]   out_dat_q [$];
  logic [3:0]           out_ch_q  [$];
  int                   out_cyc_q [$];
  int                   acc_cyc_q [$];
  int                   done_cnt;
  int                   done_cyc;
  int                   busy_cnt;
  int                   stall_acc;
  int                   head_changed;
  int                   timed_out;

  task automatic write_cfg(input logic [3:0] addr, input logic [7:0] data);
    @(negedge i_clk);
    i_cfg_we   = 1'b1;
    i_cfg_addr = addr;
    i_cfg_data = data;
    @(negedge i_clk);
    i_cfg_we   = 1'b0;
  endtask

  // Runs one job and records accepts, outputs, done pulses and stall behaviour.
  task automatic run_job(input logic [4:0] nch, input int len, input int stall,
                         input int cfg_cyc, input logic [3:0] caddr, input logic [7:0] cdata);
    int                 sent;
    logic               head_seen;
    logic [LANES*8+3:0] head_d;
    out_dat_q.delete();
    out_ch_q.delete();
    out_cyc_q.delete();
    acc_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; stall_acc = 0; head_changed = 0;
    sent = 0; head_seen = 1'b0; head_d = '0;
    for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
      @(negedge i_clk);
      i_start         = (cyc == 0);
      i_num_ch        = nch;
      i_total_len     = 16'(len);
      i_cfg_we        = (cyc == cfg_cyc);
      i_cfg_addr      = caddr;
      i_cfg_data      = cdata;
      bus.i_out_ready = (cyc > stall);
      bus.i_in_valid  = (sent < len);
      bus.i_in_dat    = {LANES{stim[sent < 32 ? sent : 0]}};
      #1;
      if (bus.i_in_valid && bus.o_in_ready) begin
        acc_cyc_q.push_back(cyc);
        if (!bus.i_out_ready) stall_acc++;
        sent++;
      end
      if (bus.o_out_valid && !bus.i_out_ready) begin
        if (head_seen && (head_d !== {bus.o_out_dat, bus.o_out_ch})) head_changed = 1;
        head_seen = 1'b1;
        head_d    = {bus.o_out_dat, bus.o_out_ch};
      end
      if (bus.o_out_valid && bus.i_out_ready) begin
        out_dat_q.push_back(bus.o_out_dat);
        out_ch_q.push_back(bus.o_out_ch);
        out_cyc_q.push_back(cyc);
      end
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    timed_out = (done_cnt == 0);
    for (int t = 0; t < 3; t++) begin
      @(negedge i_clk);
      i_start         = 1'b0;
      i_cfg_we        = 1'b0;
      bus.i_in_valid  = 1'b0;
      bus.i_out_ready = 1'b1;
      #1;
      if (bus.o_out_valid) begin
        out_dat_q.push_back(bus.o_out_dat);
        out_ch_q.push_back(bus.o_out_ch);
        out_cyc_q.push_back(-1);
      end
      if (o_busy) busy_cnt++;
      if (o_done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = 4'd0; i_cfg_data = 8'd0;
    i_start = 1'b0; i_num_ch = 5'd1; i_total_len = 16'd0;
    bus.i_in_valid = 1'b0; bus.i_in_dat = '0; bus.i_out_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({bus.o_in_ready, bus.o_out_valid, o_busy, o_done, bus.o_rnd_shift_en,
         bus.o_rnd_round_mode, bus.o_rnd_shift_num} !== 12'd0) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl: got %b want 0", {bus.o_in_ready, bus.o_out_valid, o_busy,
               o_done, bus.o_rnd_shift_en, bus.o_rnd_round_mode, bus.o_rnd_shift_num});
    end
    n_cmp++;
    if ({bus.o_out_dat, bus.o_out_ch} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_out: got %h/%h want 0/0", bus.o_out_dat, bus.o_out_ch);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    bus.i_in_valid = 1'b1;
    bus.i_in_dat   = {LANES{16'h1234}};
    #1;
    n_cmp++;
    if ({bus.o_in_ready, bus.o_rnd_dat} !== '0) begin
      n_err++;
      $display("[TB] FAIL idle_rnd_hold: got ready=%b rnd=%h want 0/0", bus.o_in_ready, bus.o_rnd_dat);
    end
    bus.i_in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4];
    logic [3:0] exp_c [4];
    exp_d = '{8'h02, 8'h7F, 8'h02, 8'h7F};
    exp_c = '{4'd0, 4'd1, 4'd0, 4'd1};
    write_cfg(4'd0, 8'b1_01_01000);
    write_cfg(4'd1, 8'h00);
    stim[0] = 16'h0180; stim[1] = 16'h0100; stim[2] = 16'h0180; stim[3] = 16'h0100;
    run_job(5'd2, 4, 0, -1, 4'd0, 8'd0);
    n_cmp++;
    if (timed_out !== 0) begin n_err++; $display("[TB] FAIL basic_timeout: got %0d want 0", timed_out); end
    n_cmp++;
    if (out_dat_q.size() !== 4) begin
      n_err++; $display("[TB] FAIL basic_count: got %0d want 4", out_dat_q.size());
    end
    for (int i = 0; i < 4 && i < out_dat_q.size(); i++) begin
      n_cmp++;
      if ({out_dat_q[i], out_ch_q[i]} !== {{LANES{exp_d[i]}}, exp_c[i]}) begin
        n_err++;
        $display("[TB] FAIL basic_beat%0d: got %h/%0d want %h/%0d", i, out_dat_q[i], out_ch_q[i],
                 {LANES{exp_d[i]}}, exp_c[i]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_err++; $display("[TB] FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    if (out_cyc_q.size() == 4) begin
      n_cmp++;
      if (done_cyc !== out_cyc_q[3] + 2) begin
        n_err++; $display("[TB] FAIL basic_done_time: got %0d want %0d", done_cyc, out_cyc_q[3] + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [6];
    exp_d = '{8'h02, 8'h7F, 8'h03, 8'h50, 8'hFF, 8'h80};
    stim[0] = 16'h0180; stim[1] = 16'h0100; stim[2] = 16'h0280;
    stim[3] = 16'h0050; stim[4] = 16'hFF00; stim[5] = 16'h8000;
    run_job(5'd2, 6, 10, -1, 4'd0, 8'd0);
    n_cmp++;
    if (timed_out !== 0) begin n_err++; $display("[TB] FAIL bp_timeout: got %0d want 0", timed_out); end
    n_cmp++;
    if (stall_acc !== 2) begin n_err++; $display("[TB] FAIL bp_stall_accepts: got %0d want 2", stall_acc); end
    n_cmp++;
    if (head_changed !== 0) begin n_err++; $display("[TB] FAIL bp_head_stable: got %0d want 0", head_changed); end
    n_cmp++;
    if (out_dat_q.size() !== 6) begin
      n_err++; $display("[TB] FAIL bp_count: got %0d want 6", out_dat_q.size());
    end
    for (int i = 0; i < 6 && i < out_dat_q.size(); i++) begin
      n_cmp++;
      if ({out_dat_q[i], out_ch_q[i]} !== {{LANES{exp_d[i]}}, 4'(i % 2)}) begin
        n_err++;
        $display("[TB] FAIL bp_beat%0d: got %h/%0d want %h/%0d", i, out_dat_q[i], out_ch_q[i],
                 {LANES{exp_d[i]}}, i % 2);
      end
    end
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 8; i++) stim[i] = 16'(16'h0100 * i);
    run_job(5'd1, 8, 0, -1, 4'd0, 8'd0);
    n_cmp++;
    if (timed_out !== 0) begin n_err++; $display("[TB] FAIL tp_timeout: got %0d want 0", timed_out); end
    n_cmp++;
    if ((acc_cyc_q.size() !== 8) || (out_dat_q.size() !== 8)) begin
      n_err++;
      $display("[TB] FAIL tp_counts: got %0d/%0d want 8/8", acc_cyc_q.size(), out_dat_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if ({acc_cyc_q[i], out_cyc_q[i]} !== {acc_cyc_q[0] + i, acc_cyc_q[0] + 2 + i}) begin
          n_err++;
          $display("[TB] FAIL tp_timing%0d: got acc=%0d out=%0d want acc=%0d out=%0d", i,
                   acc_cyc_q[i], out_cyc_q[i], acc_cyc_q[0] + i, acc_cyc_q[0] + 2 + i);
        end
        n_cmp++;
        if (out_dat_q[i] !== {LANES{8'(i)}}) begin
          n_err++; $display("[TB] FAIL tp_data%0d: got %h want %h", i, out_dat_q[i], {LANES{8'(i)}});
        end
      end
    end
  endtask

  task automatic test_zero_len_lockout();
    run_job(5'd1, 0, 0, -1, 4'd0, 8'd0);
    n_cmp++;
    if ({busy_cnt, done_cnt, out_dat_q.size(), timed_out} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
      n_err++;
      $display("[TB] FAIL zero_len: got busy=%0d done=%0d outs=%0d to=%0d want 1/1/0/0",
               busy_cnt, done_cnt, out_dat_q.size(), timed_out);
    end
    stim[0] = 16'h0180; stim[1] = 16'h0180;
    run_job(5'd1, 2, 0, 2, 4'd0, 8'h00);
    n_cmp++;
    if ((out_dat_q.size() !== 2) || (out_dat_q[0] !== {LANES{8'h02}}) || (out_dat_q[1] !== {LANES{8'h02}})) begin
      n_err++; $display("[TB] FAIL lockout_same_job: got n=%0d first=%h want 2/%h",
                        out_dat_q.size(), out_dat_q.size() > 0 ? out_dat_q[0] : '0, {LANES{8'h02}});
    end
    run_job(5'd1, 1, 0, -1, 4'd0, 8'd0);
    n_cmp++;
    if ((out_dat_q.size() !== 1) || (out_dat_q[0] !== {LANES{8'h02}})) begin
      n_err++; $display("[TB] FAIL lockout_next_job: got n=%0d data=%h want 1/%h",
                        out_dat_q.size(), out_dat_q.size() > 0 ? out_dat_q[0] : '0, {LANES{8'h02}});
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ed;
    for (int i = 0; i < 17; i++) stim[i] = 16'h0180;
    run_job(5'd0, 3, 0, -1, 4'd0, 8'd0);
    n_cmp++;
    if (out_ch_q.size() !== 3) begin
      n_err++; $display("[TB] FAIL nch0_count: got %0d want 3", out_ch_q.size());
    end
    for (int i = 0; i < 3 && i < out_ch_q.size(); i++) begin
      n_cmp++;
      if ({out_dat_q[i], out_ch_q[i]} !== {{LANES{8'h02}}, 4'd0}) begin
        n_err++; $display("[TB] FAIL nch0_beat%0d: got %h/%0d want %h/0", i, out_dat_q[i], out_ch_q[i], {LANES{8'h02}});
      end
    end
    run_job(5'd16, 17, 0, -1, 4'd0, 8'd0);
    n_cmp++;
    if (out_ch_q.size() !== 17) begin
      n_err++; $display("[TB] FAIL wrap16_count: got %0d want 17", out_ch_q.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        ed = (i % 16 == 0) ? 8'h02 : 8'h7F;
        n_cmp++;
        if ({out_dat_q[i], out_ch_q[i]} !== {{LANES{ed}}, 4'(i % 16)}) begin
          n_err++; $display("[TB] FAIL wrap16_beat%0d: got %h/%0d want %h/%0d", i,
                            out_dat_q[i], out_ch_q[i], {LANES{ed}}, i % 16);
        end
      end
      n_cmp++;
      if (out_ch_q[16] !== 4'd0) begin n_err++; $display("[TB] FAIL wrap16_last_tag: got %0d want 0", out_ch_q[16]); end
    end
  endtask

  task automatic test_reset_mid_job();
    stim[0] = 16'h0180;
    @(negedge i_clk);
    i_start = 1'b1; i_num_ch = 5'd1; i_total_len = 16'd4;
    bus.i_out_ready = 1'b0; bus.i_in_valid = 1'b1; bus.i_in_dat = {LANES{16'h0180}};
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    n_cmp++;
    if ({bus.o_out_valid, bus.o_in_ready, o_busy} !== 3'b101) begin
      n_err++; $display("[TB] FAIL midrst_pre: got %b want 101", {bus.o_out_valid, bus.o_in_ready, o_busy});
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    n_cmp++;
    if ({bus.o_out_valid, o_busy, bus.o_in_ready, o_done} !== 4'b0000) begin
      n_err++; $display("[TB] FAIL midrst_post: got %b want 0000", {bus.o_out_valid, o_busy, bus.o_in_ready, o_done});
    end
    @(negedge i_clk);
    i_rst = 1'b0; bus.i_in_valid = 1'b0; bus.i_out_ready = 1'b1;
    @(negedge i_clk);
    #1;
    n_cmp++;
    if (bus.o_out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL midrst_drop: got %b want 0", bus.o_out_valid);
    end
    run_job(5'd1, 1, 0, -1, 4'd0, 8'd0);
    n_cmp++;
    if ({timed_out, done_cnt, out_dat_q.size()} !== {32'd0, 32'd1, 32'd1}) begin
      n_err++; $display("[TB] FAIL midrst_job: got to=%0d done=%0d outs=%0d want 0/1/1",
                        timed_out, done_cnt, out_dat_q.size());
    end else begin
      n_cmp++;
      if ({out_dat_q[0], out_ch_q[0]} !== {{LANES{8'h7F}}, 4'd0}) begin
        n_err++; $display("[TB] FAIL midrst_tbl_clear: got %h/%0d want %h/0", out_dat_q[0], out_ch_q[0], {LANES{8'h7F}});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_throughput();
    test_zero_len_lockout();
    test_wrap();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
